// File: rtl/ulpb_node_rx.sv
// rtl/ulpb_node_rx.sv - ULPB node bus-side receiver: sync, frame decode, byte handoff to core.
// Optional ULPB_RX_BROADCAST_EN: all-ones address is accepted as this node's address.
module ulpb_node_rx #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] NODE_ADDR = ADDR_WIDTH'(8'h5A),
  parameter int unsigned IDLE_TIMEOUT = 32
) (
  input  logic       CLK_IN,
  input  logic       RESET,
  input  logic       BUS_CLK,
  input  logic       DIN,
  output logic       DOUT,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       RX_START,
  output logic       RX_DONE,
  output logic       RX_OVF,
  output logic       RX_PARTIAL
);

  localparam int unsigned TO_W = $clog2(IDLE_TIMEOUT) + 1;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ADDR, S_DATA, S_IGNORE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  bclk_s1_q, bclk_s1_d, bclk_s2_q, bclk_s2_d, bclk_prev_q, bclk_prev_d;
  logic                  din_s1_q, din_s1_d, din_s2_q, din_s2_d;
  logic                  dout_q, dout_d;
  logic                  bit_valid_q, bit_valid_d, bit_q, bit_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [ADDR_WIDTH-2:0] addr_sr_q, addr_sr_d;
  logic [6:0]            data_sr_q, data_sr_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_start_q, rx_start_d;
  logic                  rx_done_q, rx_done_d;
  logic                  rx_ovf_q, rx_ovf_d;
  logic                  rx_partial_q, rx_partial_d;

  logic                  bclk_rise, active, timeout, addr_match;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [7:0]            byte_next;

  assign bclk_rise = bclk_s2_q & ~bclk_prev_q;
  assign addr_next = {addr_sr_q, bit_q};
  assign byte_next = {data_sr_q, bit_q};
  assign active    = (state_q == S_ARB) || (state_q == S_ADDR) ||
                     (state_q == S_DATA) || (state_q == S_IGNORE);
  assign timeout   = active && (to_cnt_q == TO_W'(IDLE_TIMEOUT - 1));

`ifdef ULPB_RX_BROADCAST_EN
  assign addr_match = (addr_next == NODE_ADDR) || (addr_next == '1);
`else
  assign addr_match = (addr_next == NODE_ADDR);
`endif

  always_comb begin
    bclk_s1_d    = BUS_CLK;
    bclk_s2_d    = bclk_s1_q;
    bclk_prev_d  = bclk_s2_q;
    din_s1_d     = DIN;
    din_s2_d     = din_s1_q;
    dout_d       = DIN;
    // Edges seen in IDLE are never bits; this keeps a start-adjacent edge out of ARB.
    bit_valid_d  = bclk_rise && (state_q != S_IDLE);
    bit_d        = din_s2_q;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    addr_sr_d    = addr_sr_q;
    data_sr_d    = data_sr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_ovf_d     = rx_ovf_q;
    rx_partial_d = rx_partial_q;
    rx_start_d   = 1'b0;
    rx_done_d    = 1'b0;
    to_cnt_d     = (active && bclk_s2_q) ? to_cnt_q + TO_W'(1) : '0;

    if (rx_valid_q && RX_READY) rx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        addr_sr_d = '0;
        data_sr_d = '0;
        if (!din_s2_q && bclk_s2_q) state_d = S_ARB;
      end
      S_ARB: begin
        if (timeout)          state_d = S_IDLE;
        else if (bit_valid_q) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (timeout) begin
          state_d = S_IDLE;
        end else if (bit_valid_q) begin
          addr_sr_d = addr_next[ADDR_WIDTH-2:0];
          if (bit_cnt_q == 5'(ADDR_WIDTH - 1)) begin
            bit_cnt_d = '0;
            if (addr_match) begin
              state_d    = S_DATA;
              rx_start_d = 1'b1;
              rx_ovf_d   = 1'b0;
            end else begin
              state_d = S_IGNORE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      S_DATA: begin
        if (timeout) begin
          state_d = S_DONE;
        end else if (bit_valid_q) begin
          data_sr_d = byte_next[6:0];
          bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
          // A same-cycle handshake frees the buffer before the new byte lands.
          if (bit_cnt_q[2:0] == 3'd7) begin
            if (!rx_valid_q || RX_READY) begin
              rx_data_d  = byte_next;
              rx_valid_d = 1'b1;
            end else begin
              rx_ovf_d = 1'b1;
            end
          end
        end
      end
      S_IGNORE: begin
        if (timeout) state_d = S_IDLE;
      end
      S_DONE: begin
        rx_done_d    = 1'b1;
        rx_partial_d = |bit_cnt_q[2:0];
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      bclk_s1_q    <= 1'b1;
      bclk_s2_q    <= 1'b1;
      bclk_prev_q  <= 1'b1;
      din_s1_q     <= 1'b1;
      din_s2_q     <= 1'b1;
      dout_q       <= 1'b1;
      bit_valid_q  <= 1'b0;
      bit_q        <= 1'b0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      addr_sr_q    <= '0;
      data_sr_q    <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_start_q   <= 1'b0;
      rx_done_q    <= 1'b0;
      rx_ovf_q     <= 1'b0;
      rx_partial_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bclk_s1_q    <= bclk_s1_d;
      bclk_s2_q    <= bclk_s2_d;
      bclk_prev_q  <= bclk_prev_d;
      din_s1_q     <= din_s1_d;
      din_s2_q     <= din_s2_d;
      dout_q       <= dout_d;
      bit_valid_q  <= bit_valid_d;
      bit_q        <= bit_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      addr_sr_q    <= addr_sr_d;
      data_sr_q    <= data_sr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_start_q   <= rx_start_d;
      rx_done_q    <= rx_done_d;
      rx_ovf_q     <= rx_ovf_d;
      rx_partial_q <= rx_partial_d;
    end
  end

  assign DOUT       = dout_q;
  assign RX_DATA    = rx_data_q;
  assign RX_VALID   = rx_valid_q;
  assign RX_START   = rx_start_q;
  assign RX_DONE    = rx_done_q;
  assign RX_OVF     = rx_ovf_q;
  assign RX_PARTIAL = rx_partial_q;

endmodule

// File: tb/tb_ulpb_node_rx.sv
// tb/tb_ulpb_node_rx.sv - self-checking bench for ulpb_node_rx.
module tb_ulpb_node_rx;

  localparam int HALF = 4;
  localparam int TO   = 32;

`ifdef ULPB_RX_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic       CLK_IN = 1'b0;
  logic       RESET = 1'b1;
  logic       BUS_CLK = 1'b1;
  logic       DIN = 1'b1;
  logic       RX_READY = 1'b0;
  logic       DOUT;
  logic [7:0] RX_DATA;
  logic       RX_VALID, RX_START, RX_DONE, RX_OVF, RX_PARTIAL;

  always #5 CLK_IN = ~CLK_IN;

  ulpb_node_rx #(.ADDR_WIDTH(8), .NODE_ADDR(8'h5A), .IDLE_TIMEOUT(TO)) dut (
    .CLK_IN(CLK_IN), .RESET(RESET), .BUS_CLK(BUS_CLK), .DIN(DIN), .DOUT(DOUT),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY), .RX_START(RX_START),
    .RX_DONE(RX_DONE), .RX_OVF(RX_OVF), .RX_PARTIAL(RX_PARTIAL)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         n_start = 0, n_done = 0, n_valid = 0, dout_err = 0;
  logic       last_partial = 1'b0;
  logic       prev_din = 1'b1, prev_rst = 1'b1;

  typedef struct {
    logic [7:0]      addr;
    int              nbytes;
    logic [2:0][7:0] bytes;
    int              extra;
    bit              match;
    bit              partial;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK_IN) begin
    if (!RESET) begin
      if (RX_START) n_start++;
      if (RX_DONE) begin
        n_done++;
        last_partial = RX_PARTIAL;
      end
      if (RX_VALID) n_valid++;
      if (RX_VALID && RX_READY) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_byte_unexpected: got %0h expected none", RX_DATA);
        end else begin
          check("rx_data", 32'(RX_DATA), 32'(exp_q.pop_front()));
        end
      end
      if (!prev_rst && DOUT !== prev_din) dout_err++;
    end
    prev_din = DIN;
    prev_rst = RESET;
  end

  task automatic bus_fall(input logic b);
    @(posedge CLK_IN); #1;
    BUS_CLK = 1'b0;
    DIN = b;
    repeat (HALF) @(posedge CLK_IN);
  endtask

  task automatic bus_rise();
    #1 BUS_CLK = 1'b1;
    repeat (HALF - 1) @(posedge CLK_IN);
  endtask

  task automatic bus_bit(input logic b);
    bus_fall(b);
    bus_rise();
  endtask

  task automatic send_byte(input logic [7:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) bus_bit(v[7-i]);
  endtask

  task automatic frame_begin(input logic [7:0] addr);
    @(posedge CLK_IN); #1 DIN = 1'b0;
    repeat (HALF) @(posedge CLK_IN);
    bus_bit(1'b0);
    send_byte(addr, 8);
  endtask

  task automatic frame_end();
    @(posedge CLK_IN); #1 DIN = 1'b1;
    repeat (TO + 16) @(posedge CLK_IN);
  endtask

  task automatic drain();
    @(posedge CLK_IN); #1 RX_READY = 1'b1;
    @(posedge CLK_IN); #1 RX_READY = 1'b0;
    @(negedge CLK_IN);
  endtask

  initial begin
    int s0, d0, v0;
    vecs[0] = '{8'h5A, 2, {8'h00, 8'h3C, 8'hA5}, 0, 1'b1, 1'b0};
    vecs[1] = '{8'h11, 3, {8'h03, 8'h02, 8'h01}, 0, 1'b0, 1'b0};
    vecs[2] = '{8'h5A, 1, {8'h00, 8'h00, 8'hFF}, 4, 1'b1, 1'b1};
    vecs[3] = '{8'hFF, 1, {8'h00, 8'h00, 8'h77}, 0, BCAST, 1'b0};
    vecs[4] = '{8'h5A, 3, {8'h7E, 8'h80, 8'h00}, 0, 1'b1, 1'b0};

    repeat (2) @(negedge CLK_IN);
    check("rst_dout", 32'(DOUT), 1);
    check("rst_data", 32'(RX_DATA), 0);
    check("rst_valid", 32'(RX_VALID), 0);
    check("rst_start", 32'(RX_START), 0);
    check("rst_done", 32'(RX_DONE), 0);
    check("rst_ovf", 32'(RX_OVF), 0);
    check("rst_partial", 32'(RX_PARTIAL), 0);
    @(posedge CLK_IN); #1;
    RESET = 1'b0;
    RX_READY = 1'b1;
    repeat (5) @(posedge CLK_IN);

    for (int k = 0; k < 5; k++) begin
      s0 = n_start; d0 = n_done; v0 = n_valid;
      if (vecs[k].match)
        for (int j = 0; j < vecs[k].nbytes; j++) exp_q.push_back(vecs[k].bytes[j]);
      frame_begin(vecs[k].addr);
      for (int j = 0; j < vecs[k].nbytes; j++) send_byte(vecs[k].bytes[j], 8);
      for (int j = 0; j < vecs[k].extra; j++) bus_bit(1'b1);
      frame_end();
      check($sformatf("v%0d_start", k), 32'(n_start - s0), 32'(vecs[k].match));
      check($sformatf("v%0d_done", k), 32'(n_done - d0), 32'(vecs[k].match));
      check($sformatf("v%0d_valid_cycles", k), 32'(n_valid - v0),
            vecs[k].match ? 32'(vecs[k].nbytes) : 32'd0);
      if (vecs[k].match) check($sformatf("v%0d_partial", k), 32'(last_partial), 32'(vecs[k].partial));
      check($sformatf("v%0d_ovf", k), 32'(RX_OVF), 0);
      check($sformatf("v%0d_sb_empty", k), 32'(exp_q.size()), 0);
    end

    // Overflow: second byte lost while the first sits unconsumed.
    @(posedge CLK_IN); #1 RX_READY = 1'b0;
    exp_q.push_back(8'h01);
    frame_begin(8'h5A);
    send_byte(8'h01, 8);
    send_byte(8'h02, 8);
    frame_end();
    check("ovf_data", 32'(RX_DATA), 32'h01);
    check("ovf_valid", 32'(RX_VALID), 1);
    check("ovf_flag", 32'(RX_OVF), 1);
    drain();
    check("ovf_drained", 32'(RX_VALID), 0);

    // Handshake lands on the exact cycle the second byte completes.
    s0 = n_start;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    frame_begin(8'h5A);
    send_byte(8'h01, 8);
    send_byte(8'h02, 7);
    bus_fall(1'b0);
    #1 BUS_CLK = 1'b1;
    repeat (3) @(posedge CLK_IN);
    #1 RX_READY = 1'b1;
    @(posedge CLK_IN); #1 RX_READY = 1'b0;
    frame_end();
    check("same_cycle_start", 32'(n_start - s0), 1);
    check("same_cycle_data", 32'(RX_DATA), 32'h02);
    check("same_cycle_valid", 32'(RX_VALID), 1);
    check("same_cycle_ovf", 32'(RX_OVF), 0);
    drain();
    check("same_cycle_sb_empty", 32'(exp_q.size()), 0);

    // Reset in the middle of a data byte.
    frame_begin(8'h5A);
    send_byte(8'h33, 8);
    send_byte(8'h44, 8);
    send_byte(8'hF0, 5);
    check("pre_rst_ovf", 32'(RX_OVF), 1);
    check("pre_rst_valid", 32'(RX_VALID), 1);
    @(posedge CLK_IN); #1;
    RESET = 1'b1;
    BUS_CLK = 1'b1;
    DIN = 1'b1;
    @(negedge CLK_IN);
    check("mid_rst_dout", 32'(DOUT), 1);
    check("mid_rst_data", 32'(RX_DATA), 0);
    check("mid_rst_valid", 32'(RX_VALID), 0);
    check("mid_rst_start", 32'(RX_START), 0);
    check("mid_rst_done", 32'(RX_DONE), 0);
    check("mid_rst_ovf", 32'(RX_OVF), 0);
    check("mid_rst_partial", 32'(RX_PARTIAL), 0);
    @(posedge CLK_IN); #1;
    RESET = 1'b0;
    RX_READY = 1'b1;
    repeat (5) @(posedge CLK_IN);
    s0 = n_start; d0 = n_done;
    exp_q.push_back(8'hC3);
    frame_begin(8'h5A);
    send_byte(8'hC3, 8);
    frame_end();
    check("post_rst_start", 32'(n_start - s0), 1);
    check("post_rst_done", 32'(n_done - d0), 1);
    check("post_rst_data", 32'(RX_DATA), 32'hC3);
    check("post_rst_partial", 32'(last_partial), 0);
    check("post_rst_sb_empty", 32'(exp_q.size()), 0);

    check("dout_mirror_errors", 32'(dout_err), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ulpb_node_rx.md
# ulpb_node_rx

Bus-side receive stage of a ULPB member node, sitting directly downstream of the bus controller on the ring: it consumes the controller's divided bus clock and forwarded data line. It oversamples both on the local system clock and detects the start condition. It skips the arbitration edge, shifts in an address and then data bytes MSB first, and hands matching bytes to the node core over a valid/ready port. It forwards the data line unchanged to the next ring member.

## Interface
- ADDR_WIDTH, 8, address field width in bits (2..16)
- NODE_ADDR, 8'h5A, this node's address
- IDLE_TIMEOUT, 32, CLK_IN cycles of bus clock held high that end a frame (must exceed 2×controller divider)
- CLK_IN  input  1  system clock; all logic on rising edge
- RESET  input  1  asynchronous, active-high reset
- BUS_CLK  input  1  bus clock from upstream controller (asynchronous to CLK_IN)
- DIN  input  1  bus data from upstream
- DOUT  output  1  DIN forwarded through one register; reset 1
- RX_DATA  output  8  received byte; reset 0
- RX_VALID  output  1  RX_DATA holds an unconsumed byte; reset 0
- RX_READY  input  1  core accepts RX_DATA when RX_VALID & RX_READY
- RX_START  output  1  one-cycle pulse: address matched; reset 0
- RX_DONE  output  1  one-cycle pulse: matched frame ended; reset 0
- RX_OVF  output  1  sticky: byte lost, buffer full; cleared on next RX_START; reset 0
- RX_PARTIAL  output  1  RX_DONE qualifier: trailing bits (<8) discarded; reset 0

## Operation
- BUS_CLK and DIN each pass through a 2-flop synchronizer (reset value 1). A rising edge is sync=1 & prev=0. The bit sampled is synchronized DIN in the same cycle.
- DOUT = DIN registered once; independent of state.
- States: IDLE, ARB, ADDR, DATA, IGNORE, DONE.
- IDLE: synced DIN=0 while synced BUS_CLK=1 → ARB. Bit counter and shift register cleared.
- ARB: first rising edge is arbitration; its bit is discarded → ADDR.
- ADDR: capture ADDR_WIDTH bits on rising edges. After the last bit, on match → DATA, pulse RX_START, clear RX_OVF; otherwise → IGNORE.
- DATA: shift bits into an 8-bit register. On the 8th bit, load the holding buffer and set RX_VALID. If the buffer is still full, the new byte is dropped and RX_OVF is set. RX_READY in the same cycle frees the buffer first: no overflow, new byte loaded.
- Timeout counter: counts while synced BUS_CLK=1 in ARB/ADDR/DATA/IGNORE; clears on any falling edge. On reaching IDLE_TIMEOUT-1: DATA → DONE, while ARB/ADDR/IGNORE → IDLE with no pulse.
- DONE: single cycle; pulse RX_DONE and set RX_PARTIAL=1 if the bit count mod 8 ≠ 0 (covers the controller's reset clocks) → IDLE. RX_VALID and the buffer persist across frames until consumed.
- A start condition seen while in ADDR/DATA is not restarted; only a timeout returns to IDLE.
- RESET at any time: all state to reset values, the frame in flight is dropped and RX_VALID is cleared.

## Timing
- Bus rising edge to bit capture: 3 CLK_IN cycles (2 sync + edge detect).
- 8th data edge to RX_VALID high: 4 CLK_IN cycles.
- Last address edge to RX_START: 4 CLK_IN cycles.
- Final BUS_CLK rise to RX_DONE: 2 + IDLE_TIMEOUT + 1 CLK_IN cycles.
- RX_VALID falls the cycle after the handshake unless a new byte is loaded in the same cycle.
- The minimum bus half-period is 3 CLK_IN cycles; shorter periods are unsupported.

## Configuration
- ULPB_RX_BROADCAST_EN defined: the all-ones address ({ADDR_WIDTH{1}}) also matches, and is treated as NODE_ADDR.
- ULPB_RX_BROADCAST_EN undefined: only NODE_ADDR matches; all-ones → IGNORE.

## Test plan
- Start, arb bit, address 0x5A, data 0xA5 0x3C, RX_READY tied 1 → RX_START once; RX_DATA 0xA5 then 0x3C, each with one RX_VALID cycle; RX_DONE with RX_PARTIAL=0; RX_OVF=0.
- Address 0x11 with 3 data bytes → no RX_START, RX_VALID or RX_DONE; return to IDLE after the timeout; DOUT mirrors DIN delayed by 1 cycle throughout.
- RX_READY held 0, 2 bytes 0x01 0x02 → RX_DATA=0x01 retained, RX_OVF=1; with RX_READY asserted on the exact cycle the 2nd byte completes → RX_DATA=0x02, RX_OVF=0.
- Frame 0x5A + 0xFF followed by 4 reset clocks with DIN=1 → RX_DONE with RX_PARTIAL=1; only 0xFF delivered.
- Address 0xFF with the macro defined → accepted; without the macro → ignored.
- RESET pulsed mid-DATA after 5 bits → all outputs at reset values the next cycle; the next clean frame is received correctly.
